// File: rtl/adc_readout_tx.sv
// adc_readout_tx: drains a captured ADC FIFO, frames it as
// HEADER, CHANNEL_ID, data bytes, checksum, and sends it on an 8N1 UART
// line. It then re-arms the capture block through Cap_bg.
module adc_readout_tx #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter logic [7:0]  CHANNEL_ID = 8'd0,
  parameter int unsigned MAX_LEN    = 4096
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       En,
  input  logic       Cap_end,
  input  logic       Fifo_empty,
  input  logic [7:0] Fifo_q,
  output logic       Fifo_rdreq,
  output logic       Cap_bg,
  output logic       Tx,
  output logic       Busy,
  output logic       Frame_done
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned CntW     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(BAUD_DIV - 1);
  localparam logic [12:0]     MaxLen   = 13'(MAX_LEN);

  localparam logic [3:0] StIdle  = 4'd0;
  localparam logic [3:0] StHdr   = 4'd1;
  localparam logic [3:0] StChid  = 4'd2;
  localparam logic [3:0] StRd    = 4'd3;
  localparam logic [3:0] StWait  = 4'd4;
  localparam logic [3:0] StLatch = 4'd5;
  localparam logic [3:0] StData  = 4'd6;
  localparam logic [3:0] StSum   = 4'd7;
  localparam logic [3:0] StRearm = 4'd8;

  logic [3:0]  state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [7:0]  chk_q, chk_d;
  // Set once the byte of a HDR/CHID/SUM state has been launched, so the
  // still-idle UART in the launch cycle is not mistaken for completion.
  logic        started_q, started_d;

  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        rdreq;
  logic        frame_done;

  logic            busy_q;
  logic [CntW-1:0] baud_q;
  logic [3:0]      bit_q;
  logic [8:0]      shreg_q;
  logic            tx_q;

  // UART engine: start bit, 8 data bits LSB first, stop bit; Tx registered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= 4'd0;
      shreg_q <= 9'h1ff;
      tx_q    <= 1'b1;
    end else if (tx_start) begin
      busy_q  <= 1'b1;
      baud_q  <= '0;
      bit_q   <= 4'd0;
      shreg_q <= {1'b1, tx_byte};
      tx_q    <= 1'b0;
    end else if (busy_q) begin
      if (baud_q == BaudLast) begin
        baud_q <= '0;
        if (bit_q == 4'd9) begin
          busy_q <= 1'b0;
          tx_q   <= 1'b1;
        end else begin
          tx_q    <= shreg_q[0];
          shreg_q <= {1'b1, shreg_q[8:1]};
          bit_q   <= bit_q + 4'd1;
        end
      end else begin
        baud_q <= baud_q + 1'b1;
      end
    end
  end

  // Frame sequencer state, data counter and checksum registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      cnt_q     <= 13'd0;
      chk_q     <= 8'd0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      chk_q     <= chk_d;
      started_q <= started_d;
    end
  end

  // Frame sequencer next-state and strobes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    chk_d      = chk_q;
    started_d  = started_q;
    tx_start   = 1'b0;
    tx_byte    = 8'h00;
    rdreq      = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (En && Cap_end) begin
          cnt_d     = 13'd0;
          chk_d     = 8'd0;
          started_d = 1'b0;
          state_d   = StHdr;
        end
      end
      StHdr: begin
        if (!started_q) begin
          tx_start  = 1'b1;
          tx_byte   = HEADER;
          started_d = 1'b1;
        end else if (!busy_q) begin
          started_d = 1'b0;
          state_d   = StChid;
        end
      end
      StChid: begin
        if (!started_q) begin
          tx_start  = 1'b1;
          tx_byte   = CHANNEL_ID;
          started_d = 1'b1;
        end else if (!busy_q) begin
          started_d = 1'b0;
          state_d   = StRd;
        end
      end
      StRd: begin
        if (Fifo_empty || (cnt_q == MaxLen)) begin
          state_d = StSum;
        end else begin
          rdreq   = 1'b1;
          state_d = StWait;
        end
      end
      StWait: state_d = StLatch;
      StLatch: begin
        tx_start = 1'b1;
        tx_byte  = Fifo_q;
        chk_d    = chk_q + Fifo_q;
        cnt_d    = cnt_q + 13'd1;
        state_d  = StData;
      end
      StData: begin
        if (!busy_q) state_d = StRd;
      end
      StSum: begin
        if (!started_q) begin
          tx_start  = 1'b1;
          tx_byte   = chk_q;
          started_d = 1'b1;
        end else if (!busy_q) begin
          frame_done = 1'b1;
          started_d  = 1'b0;
          state_d    = StRearm;
        end
      end
      StRearm: begin
        if (!Cap_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode.
  always_comb begin
    Fifo_rdreq = rdreq;
    Frame_done = frame_done;
    Cap_bg     = (state_q == StRearm);
    Busy       = (state_q != StIdle);
    Tx         = tx_q;
  end

endmodule

// File: doc/adc_readout_tx.md
# adc_readout_tx

Readout side of an ADC capture channel. After a capture is complete and the channel's FIFO holds the samples, this block drains the FIFO. It frames the bytes and sends them to the MCU over an 8N1 UART line. It then re-arms the capture channel through the begin strobe. One instance is used per ADC channel; the MCU tells channels apart by the channel-ID byte.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: UART bit rate. BAUD_DIV = CLK_FREQ/BAUD, integer division.
- HEADER, 8'hA5: first byte of every frame.
- CHANNEL_ID, 8'd0: second byte of every frame.
- MAX_LEN, 4096: maximum number of data bytes per frame.

- Clk, input, 1: system clock.
- Reset, input, 1: synchronous, active-high reset.
- En, input, 1: readout enable, sampled in IDLE only.
- Cap_end, input, 1: capture-complete level from the capture block.
- Fifo_empty, input, 1: FIFO empty flag.
- Fifo_q, input, 8: FIFO read data, valid the cycle after Fifo_rdreq.
- Fifo_rdreq, output, 1: FIFO read request, one-cycle pulse per byte.
- Cap_bg, output, 1: re-arm request to the capture block.
- Tx, output, 1: UART serial out, idle high.
- Busy, output, 1: high in every state except IDLE.
- Frame_done, output, 1: one-cycle pulse when the frame's last stop bit ends.

## Operation
- Frame format: HEADER, CHANNEL_ID, then D bytes, then CHK.
  - D is in the range 0..MAX_LEN.
  - CHK is the 8-bit sum of the data bytes only, modulo 256.
- UART engine: a 10-bit frame (start 0, 8 data bits LSB first, stop 1). Each bit lasts BAUD_DIV cycles. A `tx_start` pulse loads the shift register. `tx_idle` returns high the same cycle the stop bit ends.
- Data counter: 13 bits. Checksum accumulator: 8 bits, wraps silently.
- State machine:
  - IDLE: if En && Cap_end, clear the counter and checksum, then go to HDR.
  - HDR: start HEADER, then wait for tx_idle. Go to CHID.
  - CHID: start CHANNEL_ID, then wait for tx_idle. Go to RD.
  - RD: if Fifo_empty or count == MAX_LEN, go to SUM. Otherwise assert Fifo_rdreq for one cycle and go to WAIT.
  - WAIT: one cycle. Go to LATCH.
  - LATCH: capture Fifo_q into the shift register, add it to the checksum, increment the count, start the UART. Go to DATA.
  - DATA: wait for tx_idle. Go to RD.
  - SUM: start CHK, then wait for tx_idle. Pulse Frame_done and go to REARM.
  - REARM: hold Cap_bg high until Cap_end is sampled low, then drop Cap_bg and go to IDLE.
- Fifo_rdreq is never asserted while Fifo_empty is high, or outside RD.
- Cap_end falling during HDR through SUM is ignored: the frame always completes.
- En low mid-frame is ignored: the frame always completes.
- When count reaches MAX_LEN with the FIFO non-empty, the remaining bytes stay in the FIFO. They are cleared by the capture block's sclr after re-arm.

## Timing
- Reset values:
  - Tx = 1
  - Fifo_rdreq = 0
  - Cap_bg = 0
  - Busy = 0
  - Frame_done = 0
  - State = IDLE; counter and checksum = 0.
- Reset mid-byte: Tx returns to 1 on the next cycle and the frame is abandoned. No rdreq is issued afterwards until a new Cap_end is seen in IDLE.
- The start bit goes low 2 cycles after Cap_end is sampled high in IDLE (one cycle to enter HDR, one to register Tx).
- Gap between consecutive data bytes on Tx: 3 cycles of idle-high (RD, WAIT, LATCH) plus the output register.
- Total frame duration: (D+3) × (10×BAUD_DIV + 3) cycles, ±3 cycles.
- Frame_done coincides with the cycle in which tx_idle rises after CHK.
- Cap_bg rises the cycle after Frame_done. It falls the cycle after Cap_end is seen low.

## Test plan
- Basic frame: use BAUD_DIV = 4. Preload the FIFO with 0x01, 0x02, 0x03, raise Cap_end, En = 1. Tx must decode to A5 00 01 02 03 06. There must be exactly 3 rdreq pulses and one Frame_done.
- Empty FIFO: raise Cap_end with Fifo_empty = 1. Frame must be A5 00 00 with zero rdreq pulses, then Cap_bg asserts.
- Checksum wrap: data 0xFF, 0x02. CHK must be 0x01.
- MAX_LEN cap: use MAX_LEN = 4 with 6 bytes preloaded. Exactly 4 data bytes are sent and 2 remain in the FIFO.
- Re-arm handshake: hold Cap_end high for 20 cycles after Frame_done. Cap_bg must stay high throughout and fall 1 cycle after Cap_end drops. No new frame may start until Cap_end rises again.
- Reset mid-data-byte: pulse Reset during bit 4 of the second data byte. Tx = 1, Busy = 0 and Fifo_rdreq = 0 on the next cycle, and there is no further activity while Cap_end stays low.
